// File: rtl/control_hazard.sv
// Pipeline hazard unit: tracks register writers in flight, drives load-use stall,
// jump/branch flushes and registered ALU operand forward selects for EX.
module control_hazard #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              idValid,
    input  logic              idIsFunc,
    input  logic [1:0]        idPcAction,
    input  logic [1:0]        idRegWriteAddrSource,
    input  logic              idRegWriteDataSource,
    input  logic              idReg1AddrSource,
    input  logic [1:0]        idAluData2Source,
    input  logic              idShamtConst16,
    input  logic              idMemWrite,
    input  logic [ADDR_W-1:0] idRs,
    input  logic [ADDR_W-1:0] idRt,
    input  logic [ADDR_W-1:0] idRd,
    input  logic              exBranchTaken,
    output logic              stall,
    output logic              flushIf,
    output logic              flushId,
    output logic [1:0]        forward1Ex,
    output logic [1:0]        forward2Ex,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  flushCount
);

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2
    } pc_action_e;

    typedef enum logic [1:0] {
        WA_NONE = 2'd0,
        WA_RD   = 2'd1,
        WA_RT   = 2'd2
    } wr_addr_src_e;

    typedef enum logic [1:0] {
        A2_REG   = 2'd0,
        A2_IMM_S = 2'd1,
        A2_IMM_U = 2'd2
    } alu2_src_e;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_EXMEM   = 2'd1,
        FWD_MEMWB   = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic              is_load;
    } track_t;

    // WB is not tracked: the register file is write-before-read, so an
    // instruction in WB is already visible to decode and never forwarded.
    track_t ex_q;
    track_t mem_q;
    track_t dec_entry;

    fwd_sel_e fwd1_q;
    fwd_sel_e fwd2_q;
    fwd_sel_e fwd1_d;
    fwd_sel_e fwd2_d;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [ADDR_W-1:0] dec_dst;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              use1;
    logic              use2;
    logic              is_jump;
    logic              load_use;
    logic              ex_load;

    function automatic fwd_sel_e pick_fwd(
        input logic              used,
        input logic [ADDR_W-1:0] src,
        input track_t            ex,
        input track_t            mem
    );
        fwd_sel_e sel;
        sel = FWD_REGFILE;
        if (used) begin
            if (ex.valid && !ex.is_load && ex.dst == src) begin
                sel = FWD_EXMEM;
            end else if (mem.valid && mem.dst == src) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        dec_dst = '0;
        case (wr_addr_src_e'(idRegWriteAddrSource))
            WA_RD:   dec_dst = idRd;
            WA_RT:   dec_dst = idRt;
            default: dec_dst = '0;
        endcase
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.valid   = (dec_dst != '0);
        dec_entry.dst     = dec_dst;
        dec_entry.is_load = idRegWriteDataSource;
    end

    always_comb begin
        is_jump = (pc_action_e'(idPcAction) == PC_JUMP);
        src1    = idReg1AddrSource ? idRt : idRs;
        src2    = idRt;
        use1    = !(idShamtConst16 || (is_jump && !idIsFunc));
        use2    = (alu2_src_e'(idAluData2Source) == A2_REG) || idMemWrite;
    end

    always_comb begin
        load_use = ex_q.valid && ex_q.is_load &&
                   ((use1 && ex_q.dst == src1) || (use2 && ex_q.dst == src2));
        stall    = idValid && load_use && !exBranchTaken;
        flushId  = exBranchTaken;
        flushIf  = exBranchTaken || (idValid && is_jump && !stall);
        ex_load  = idValid && !stall && !flushId;
        fwd1_d   = pick_fwd(use1, src1, ex_q, mem_q);
        fwd2_d   = pick_fwd(use2, src2, ex_q, mem_q);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ex_q   <= '0;
            mem_q  <= '0;
            fwd1_q <= FWD_REGFILE;
            fwd2_q <= FWD_REGFILE;
        end else begin
            mem_q <= ex_q;
            if (ex_load) begin
                ex_q   <= dec_entry;
                fwd1_q <= fwd1_d;
                fwd2_q <= fwd2_d;
            end else begin
                ex_q   <= '0;
                fwd1_q <= FWD_REGFILE;
                fwd2_q <= FWD_REGFILE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flushIf && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign forward1Ex = fwd1_q;
    assign forward2Ex = fwd2_q;
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_control_hazard.sv
// Bench for control_hazard: directed test-plan sequences plus random instruction
// streams, all compared against an instruction-history reference model.
module tb_control_hazard;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              resetN;
    logic              idValid;
    logic              idIsFunc;
    logic [1:0]        idPcAction;
    logic [1:0]        idRegWriteAddrSource;
    logic              idRegWriteDataSource;
    logic              idReg1AddrSource;
    logic [1:0]        idAluData2Source;
    logic              idShamtConst16;
    logic              idMemWrite;
    logic [ADDR_W-1:0] idRs;
    logic [ADDR_W-1:0] idRt;
    logic [ADDR_W-1:0] idRd;
    logic              exBranchTaken;
    logic              stall;
    logic              flushIf;
    logic              flushId;
    logic [1:0]        forward1Ex;
    logic [1:0]        forward2Ex;
    logic [CNT_W-1:0]  stallCount;
    logic [CNT_W-1:0]  flushCount;

    always #5 clock = ~clock;

    control_hazard #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetN(resetN), .idValid(idValid), .idIsFunc(idIsFunc),
        .idPcAction(idPcAction), .idRegWriteAddrSource(idRegWriteAddrSource),
        .idRegWriteDataSource(idRegWriteDataSource), .idReg1AddrSource(idReg1AddrSource),
        .idAluData2Source(idAluData2Source), .idShamtConst16(idShamtConst16),
        .idMemWrite(idMemWrite), .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .exBranchTaken(exBranchTaken), .stall(stall), .flushIf(flushIf),
        .flushId(flushId), .forward1Ex(forward1Ex), .forward2Ex(forward2Ex),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    // Model: history of what each past cycle issued into EX (index 0 = most recent).
    typedef struct {
        bit writes;
        int dst;
        bit load;
    } issued_t;

    issued_t hist[$];
    int m_f1, m_f2, m_sc, m_fc;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        hist.push_back('{0, 0, 0});
        hist.push_back('{0, 0, 0});
        m_f1 = 0; m_f2 = 0; m_sc = 0; m_fc = 0;
    endtask

    function automatic int fwd_of(input bit used, input int src);
        if (!used) return 0;
        if (hist[0].writes && !hist[0].load && hist[0].dst == src) return 1;
        if (hist[1].writes && hist[1].dst == src) return 2;
        return 0;
    endfunction

    // One decode cycle: apply inputs, check outputs at negedge, advance model at posedge.
    task automatic cyc(input bit v, input bit fn, input int pc, input int ws, input bit wd,
                       input bit r1, input int a2, input bit sh, input bit mw,
                       input int rs, input int rt, input int rd, input bit br);
        int dst, s1, s2, f1, f2;
        bit u1, u2, hz, m_stall, m_fif, load;
        idValid = v; idIsFunc = fn; idPcAction = pc[1:0]; idRegWriteAddrSource = ws[1:0];
        idRegWriteDataSource = wd; idReg1AddrSource = r1; idAluData2Source = a2[1:0];
        idShamtConst16 = sh; idMemWrite = mw; idRs = rs[ADDR_W-1:0]; idRt = rt[ADDR_W-1:0];
        idRd = rd[ADDR_W-1:0]; exBranchTaken = br;
        dst = (ws == 1) ? rd : (ws == 2) ? rt : 0;
        s1 = r1 ? rt : rs;
        s2 = rt;
        u1 = !(sh || (pc == 1 && !fn));
        u2 = (a2 == 0) || mw;
        hz = hist[0].writes && hist[0].load &&
             ((u1 && hist[0].dst == s1) || (u2 && hist[0].dst == s2));
        m_stall = v && hz && !br;
        m_fif = br || (v && pc == 1 && !m_stall);
        f1 = fwd_of(u1, s1);
        f2 = fwd_of(u2, s2);
        @(negedge clock);
        check("stall", stall, m_stall);
        check("flushIf", flushIf, m_fif);
        check("flushId", flushId, br);
        check("forward1Ex", forward1Ex, m_f1);
        check("forward2Ex", forward2Ex, m_f2);
        check("stallCount", stallCount, m_sc);
        check("flushCount", flushCount, m_fc);
        @(posedge clock);
        load = v && !m_stall && !br;
        hist.push_front(load ? issued_t'{dst != 0, dst, wd} : issued_t'{0, 0, 0});
        void'(hist.pop_back());
        m_f1 = load ? f1 : 0;
        m_f2 = load ? f2 : 0;
        if (m_stall && m_sc < CMAX) m_sc++;
        if (m_fif && m_fc < CMAX) m_fc++;
        #1;
    endtask

    // Instruction shorthands: lw rt,(rs); R-type rd,rs,rt; addi-like rt,rs; bubble.
    task automatic lw(input int rt, input int rs);
        cyc(1, 0, 0, 2, 1, 0, 1, 0, 0, rs, rt, 0, 0);
    endtask
    task automatic rtype(input int rd, input int rs, input int rt);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, rs, rt, rd, 0);
    endtask
    task automatic itype(input int rt, input int rs);
        cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, rs, rt, 0, 0);
    endtask
    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int sc0;
        model_reset();
        idValid = 0; idIsFunc = 0; idPcAction = 0; idRegWriteAddrSource = 0;
        idRegWriteDataSource = 0; idReg1AddrSource = 0; idAluData2Source = 0;
        idShamtConst16 = 0; idMemWrite = 0; idRs = 0; idRt = 0; idRd = 0; exBranchTaken = 0;
        resetN = 1'b0;
        #3;
        check("reset_stall", stall, 0);
        check("reset_fwd1", forward1Ex, 0);
        check("reset_stallCount", stallCount, 0);
        do_reset();

        // load-use: lw $8 ; add $9,$8,$10
        lw(8, 0);
        rtype(9, 8, 10);
        rtype(9, 8, 10);
        check("lu_fwd1", forward1Ex, 2);
        check("lu_fwd2", forward2Ex, 0);
        check("lu_stallCount", stallCount, 1);
        nop(); nop();

        // EX/MEM forward on both operands
        itype(5, 0);
        rtype(6, 5, 5);
        check("alu_fwd1", forward1Ex, 1);
        check("alu_fwd2", forward2Ex, 1);
        check("alu_nostall", stallCount, 1);

        // MEM/WB forward, then EX priority over MEM
        itype(7, 0); itype(11, 0); rtype(12, 7, 0);
        check("mem_fwd1", forward1Ex, 2);
        itype(7, 0); itype(7, 0); rtype(12, 7, 0);
        check("prio_fwd1", forward1Ex, 1);

        // $0 destination never forwards
        itype(0, 3); rtype(12, 0, 0);
        check("zero_fwd1", forward1Ex, 0);
        check("zero_fwd2", forward2Ex, 0);

        // lui after lw to its rs: rs unused
        sc0 = m_sc;
        lw(4, 0);
        cyc(1, 0, 0, 2, 0, 0, 2, 1, 0, 4, 3, 0, 0);
        check("lui_nostall", stallCount, sc0);

        // sll reads rt through src1
        nop(); lw(8, 0);
        cyc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 8, 9, 0);
        check("sll_stall", stallCount, sc0 + 1);
        nop(); nop();

        // taken branch overrides a load-use stall
        lw(8, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 8, 10, 9, 1);
        check("br_ex_bubble_fwd1", forward1Ex, 0);
        check("br_stallCount", stallCount, sc0 + 1);

        // j: flushIf for one cycle only
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();

        // random streams; small register range to provoke hazards, counters saturate
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(9, 0) != 0, $urandom_range(1, 0), $urandom_range(2, 0),
                $urandom_range(2, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                $urandom_range(2, 0), $urandom_range(5, 0) == 0, $urandom_range(4, 0) == 0,
                $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(7, 0) == 0);
        end
        check("sat_flushCount", flushCount, CMAX);

        // asynchronous reset while stalled with EX and MEM occupied
        itype(2, 0); lw(8, 0);
        idValid = 1; idIsFunc = 1; idPcAction = 0; idRegWriteAddrSource = 1;
        idRegWriteDataSource = 0; idReg1AddrSource = 0; idAluData2Source = 0;
        idShamtConst16 = 0; idMemWrite = 0; idRs = 8; idRt = 2; idRd = 9; exBranchTaken = 0;
        #1;
        check("pre_reset_stall", stall, 1);
        resetN = 1'b0;
        #1;
        check("async_stall", stall, 0);
        check("async_fwd1", forward1Ex, 0);
        check("async_fwd2", forward2Ex, 0);
        check("async_stallCount", stallCount, 0);
        check("async_flushCount", flushCount, 0);
        model_reset();
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        rtype(9, 8, 2);
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_hazard.md
Name: control_hazard

Overview:
Consumer of the decoded control word: tracks register-writing instructions in flight through EX, MEM and WB, and drives the pipeline's hazard outputs. These are the load-use stall, the fetch/decode flushes for jumps and taken branches, and registered ALU operand forward selects for the instruction entering EX. It sits between the decode-stage control generator and the pipeline registers and PC logic.

Parameters:
ADDR_W, 5, register address width
CNT_W, 16, width of the stall and flush event counters

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
idValid  input  1  decode stage holds a real instruction
idIsFunc  input  1  opcode source is Func (R-type)
idPcAction  input  2  0 Inc, 1 Jump, 2 Branch
idRegWriteAddrSource  input  2  0 None, 1 Rd, 2 Rt
idRegWriteDataSource  input  1  0 Alu, 1 Memory
idReg1AddrSource  input  1  0 Rs, 1 Rt
idAluData2Source  input  2  0 Register, 1 ImmSigned, 2 ImmUnsigned
idShamtConst16  input  1  shamtSource is Const16 (lui)
idMemWrite  input  1  store
idRs, idRt, idRd  input  ADDR_W each  decode register fields
exBranchTaken  input  1  branch in EX resolved taken
stall  output  1  hold PC and IF/ID; inject bubble into EX
flushIf  output  1  squash the instruction in fetch
flushId  output  1  squash the instruction in decode
forward1Ex, forward2Ex  output  2 each  0 regfile, 1 EX/MEM result, 2 MEM/WB result
stallCount, flushCount  output  CNT_W each  saturating event counters

Behaviour:
- Decode destination: None -> no write; Rd -> idRd; Rt -> idRt. A destination of 0 counts as no write.
- src1 = idRt if idReg1AddrSource=1, else idRs.
- src1 is unused when idShamtConst16=1, or when idPcAction=Jump and idIsFunc=0 (j/jal).
- src2 = idRt. It is used when idAluData2Source=Register or idMemWrite=1.
- Tracking entries EX, MEM and WB each hold {valid, dst, isLoad}. isLoad = idRegWriteDataSource=Memory.
- Every clock, WB<=MEM and MEM<=EX.
- EX<=decode entry when idValid=1, stall=0 and flushId=0. Otherwise EX<=bubble (valid=0).
- stall (combinational) = idValid & EX.valid & EX.isLoad & EX.dst matches a used source, gated by !exBranchTaken. A single load-use stalls exactly 1 cycle.
- forward1Ex and forward2Ex are computed at decode per used source and registered when EX loads.
- Forward source priority:
  - 1 if EX.valid & !EX.isLoad & EX.dst==src;
  - else 2 if MEM.valid & MEM.dst==src;
  - else 0.
- Unused sources always give 0. A bubble loads 0 into both forward outputs.
- The register file is write-before-read, so WB needs no forward.
- flushId = exBranchTaken. flushIf = exBranchTaken | (idValid & idPcAction=Jump & !stall).
- Branch wins over stall: when exBranchTaken=1, stall is forced to 0 and flushId bubbles EX.
- stallCount increments on each cycle with stall=1. flushCount increments on each cycle with flushIf=1. Both saturate at all-ones and never wrap.
- Reset (asynchronous, any time including mid-stall): all entries invalid, forward outputs 0, counters 0.
- Deassertion of resetN is synchronised by the system. Outputs are valid on the first clock edge after release.
- Latency: stall and flush outputs are combinational from the current state and inputs. Forward selects appear one cycle after decode, aligned with EX.

Test Plan:
- Load-use: lw $8 then add $9,$8,$10 back-to-back -> stall=1 for exactly 1 cycle, stallCount=1; add enters EX with forward1Ex=2, forward2Ex=0.
- ALU forward: addi $5,$0,3 then sub $6,$5,$5 -> forward1Ex=1 and forward2Ex=1 in sub's EX cycle, no stall.
- MEM forward and priority: write $7, one unrelated instruction, then read $7 -> forward=2. Two consecutive writes of $7 then a read -> forward=1.
- Zero and unused operands:
  - ori $0,... followed by add reading $0 -> no forward, no stall.
  - lui after lw to its rs -> no stall.
  - sll reads rt via src1, and a hazard on rt is detected.
- Branch/jump: exBranchTaken=1 while a load-use stall condition is present -> stall=0, flushIf=1, flushId=1, next EX bubble, flushCount+1. j in decode -> flushIf=1 for 1 cycle only.
- Reset mid-operation: assert resetN=0 during a stall with all entries valid -> stall=0 and forwards 0 immediately; counters 0; first instruction after release sees no hazards.
